wave_addr_gen: RTL

- Upstream address/phase stage for the waveform generator LUT and shaper stages (sawtooth, triangle, sine).
- A 32-bit phase accumulator, advanced at a divided sample rate, produces a 10-bit table address, a per-sample valid strobe and a period-start flag.
- It also delivers a duty select (0..10) that only changes at period boundaries, so downstream shapes never glitch mid-period.

---
 rtl/wave_addr_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/wave_addr_gen.sv
// wave_addr_gen: phase-accumulator table address generator with divided sample tick and period-aligned duty select.
// Optional macro WAVE_ADDR_GEN_SYNC_EN adds i_sync, which restarts the period from phase 0 while running.
module wave_addr_gen #(
  parameter int CLK_DIV = 4,
  parameter int PHASE_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [PHASE_W-1:0] i_fcw,
  input  logic [3:0]         i_sel,
`ifdef WAVE_ADDR_GEN_SYNC_EN
  input  logic               i_sync,
`endif
  output logic [9:0]         o_addr,
  output logic [3:0]         o_sel,
  output logic               o_valid,
  output logic               o_wrap,
  output logic               o_busy
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state_q, state_d, active_d;
  logic [15:0] cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d, sum;
  logic new_period_q, new_period_d;
  logic [9:0] addr_q, addr_d;
  logic [3:0] sel_q, sel_d, sel_clamp;
  logic valid_q, valid_d, wrap_q, wrap_d;
  logic carry, tick, sync, stopping_now;
  assign {carry, sum} = {1'b0, phase_q} + {1'b0, i_fcw};
  assign tick = (state_q != IDLE) && (cnt_q == 16'(CLK_DIV - 1));
  assign sel_clamp = i_sel > 4'd10 ? 4'd10 : i_sel;
  // i_stop wins in RUN; i_start cancels a pending stop
  assign active_d = state_q == RUN ? (i_stop ? STOPPING : RUN) : (i_start ? RUN : STOPPING);
  assign stopping_now = (state_q == STOPPING) && !i_start;
`ifdef WAVE_ADDR_GEN_SYNC_EN
  assign sync = i_sync && (state_q != IDLE);
`else
  assign sync = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    new_period_d = new_period_q;
    addr_d = addr_q;
    sel_d = sel_q;
    valid_d = 1'b0;
    wrap_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_start) begin
        state_d = RUN;
        cnt_d = '0;
        phase_d = '0;
        new_period_d = 1'b1;
      end
    end else if (sync) begin
      state_d = active_d;
      cnt_d = '0;
      phase_d = '0;
      new_period_d = 1'b1;
    end else begin
      state_d = active_d;
      cnt_d = tick ? '0 : cnt_q + 16'd1;
      if (tick) begin
        if (stopping_now && i_fcw == '0) begin
          state_d = IDLE;
          phase_d = '0;
          new_period_d = 1'b1;
        end else begin
          addr_d = phase_q[PHASE_W-1 -: 10];
          phase_d = sum;
          valid_d = 1'b1;
          wrap_d = new_period_q;
          sel_d = new_period_q ? sel_clamp : sel_q;
          new_period_d = carry;
          if (stopping_now && carry) begin
            state_d = IDLE;
            phase_d = '0;
            new_period_d = 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      phase_q <= '0;
      new_period_q <= 1'b1;
      addr_q <= '0;
      sel_q <= '0;
      valid_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      new_period_q <= new_period_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      valid_q <= valid_d;
      wrap_q <= wrap_d;
    end
  end
  assign o_addr = addr_q;
  assign o_sel = sel_q;
  assign o_valid = valid_q;
  assign o_wrap = wrap_q;
  assign o_busy = state_q != IDLE;
endmodule
